// File: rtl/audio_sample_ctrl.sv
// Sample-memory controller for a record/playback audio path: captures ADC samples,
// plays them back to the DAC, and seeks forward/backward through the recording.
module audio_sample_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int SKIP     = 4,
  parameter int STEP_DIV = 6250
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [2:0]        State,
  input  logic              ClkAD,
  input  logic              ClkDA,
  input  logic [DATA_W-1:0] AdData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemWe,
  input  logic [DATA_W-1:0] MemRData,
  output logic [DATA_W-1:0] DaData,
  output logic [ADDR_W-1:0] RecLen,
  output logic              Full,
  output logic              PlayEnd
);

  localparam logic [2:0] MODE_REC  = 3'b001;
  localparam logic [2:0] MODE_PLAY = 3'b100;
  localparam logic [2:0] MODE_FF   = 3'b110;
  localparam logic [2:0] MODE_REW  = 3'b111;

  localparam int                CNT_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [ADDR_W-1:0] MAX_LEN   = '1;
  localparam logic [ADDR_W:0]   SKIP_X    = (ADDR_W + 1)'(SKIP);
  localparam logic [DATA_W-1:0] MIDSCALE  = {1'b1, {(DATA_W - 1){1'b0}}};

  logic [1:0]        ad_sync, da_sync;
  logic              ad_last, da_last;
  logic              ad_tick, da_tick;
  logic [2:0]        prev_state;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  step_cnt;
  logic              rd_v1, rd_v2;

  logic              is_rec, is_play, is_seek, rec_entry, play_entry;
  logic [ADDR_W-1:0] wr_base, len_base, wr_next, rd_base, ff_ptr, rew_ptr;
  logic [ADDR_W:0]   ff_sum;

  assign ad_tick = ad_sync[1] & ~ad_last;
  assign da_tick = da_sync[1] & ~da_last;

  // Entry effects are folded into the base values so a tick arriving on the
  // same edge as a mode change is served by the new mode.
  // NOTE: every always_comb output gets a value on every path, so no latches.
  always_comb begin
    is_rec     = (State == MODE_REC);
    is_play    = (State == MODE_PLAY);
    is_seek    = (State == MODE_FF) || (State == MODE_REW);
    rec_entry  = is_rec && (prev_state != MODE_REC);
    play_entry = is_play && (prev_state != MODE_PLAY);
    wr_base    = rec_entry ? '0 : wr_ptr;
    len_base   = rec_entry ? '0 : RecLen;
    wr_next    = wr_base + 1'b1;
    rd_base    = (play_entry && prev_state != MODE_FF && prev_state != MODE_REW) ? '0 : rd_ptr;
    // One extra bit so seeking saturates instead of wrapping.
    ff_sum     = {1'b0, rd_ptr} + SKIP_X;
    ff_ptr     = (ff_sum > {1'b0, RecLen}) ? RecLen : ff_sum[ADDR_W-1:0];
    rew_ptr    = ({1'b0, rd_ptr} < SKIP_X) ? '0 : rd_ptr - SKIP_X[ADDR_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only; later
  // assignments in the block intentionally override earlier defaults.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ad_sync    <= '0;
      da_sync    <= '0;
      ad_last    <= 1'b0;
      da_last    <= 1'b0;
      prev_state <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      step_cnt   <= '0;
      rd_v1      <= 1'b0;
      rd_v2      <= 1'b0;
      MemAddr    <= '0;
      MemWData   <= '0;
      MemWe      <= 1'b0;
      DaData     <= MIDSCALE;
      RecLen     <= '0;
      Full       <= 1'b0;
      PlayEnd    <= 1'b0;
    end else begin
      ad_sync    <= {ad_sync[0], ClkAD};
      da_sync    <= {da_sync[0], ClkDA};
      ad_last    <= ad_sync[1];
      da_last    <= da_sync[1];
      prev_state <= State;
      MemWe      <= 1'b0;
      rd_v1      <= 1'b0;
      rd_v2      <= rd_v1;
      if (!is_seek) step_cnt <= '0;
      if (!is_play) PlayEnd <= 1'b0;

      if (is_rec) begin
        DaData <= MIDSCALE;
        if (rec_entry) begin
          wr_ptr <= '0;
          RecLen <= '0;
          rd_ptr <= '0;
          Full   <= 1'b0;
        end
        if (ad_tick && len_base != MAX_LEN) begin
          MemAddr  <= wr_base;
          MemWData <= AdData;
          MemWe    <= 1'b1;
          wr_ptr   <= wr_next;
          RecLen   <= wr_next;
          if (wr_next == MAX_LEN) Full <= 1'b1;
        end
      end else if (is_play) begin
        if (play_entry) begin
          rd_ptr  <= rd_base;
          PlayEnd <= 1'b0;
        end
        // Read data lands two edges after the address is issued.
        if (rd_v2) DaData <= MemRData;
        if (da_tick) begin
          if (rd_base < RecLen) begin
            MemAddr <= rd_base;
            rd_ptr  <= rd_base + 1'b1;
            rd_v1   <= 1'b1;
          end else begin
            PlayEnd <= 1'b1;
            DaData  <= MIDSCALE;
          end
        end
      end else if (is_seek) begin
        DaData <= MIDSCALE;
        if (step_cnt == STEP_LAST) begin
          step_cnt <= '0;
          rd_ptr   <= (State == MODE_FF) ? ff_ptr : rew_ptr;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end else begin
        DaData <= MIDSCALE;
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_ctrl.sv
// Directed bench for audio_sample_ctrl: a wide instance for record/play/seek and
// a 4-bit-address instance for the memory-full boundary, each with a memory model.
module tb_audio_sample_ctrl;

  localparam int DW   = 8;
  localparam int BA   = 8;
  localparam int SA   = 4;
  localparam int STEP = 8;

  logic          Clk, Rst_n, ClkAD, ClkDA;
  logic [2:0]    State;
  logic [DW-1:0] AdData;

  logic [BA-1:0] b_addr, b_reclen;
  logic [DW-1:0] b_wdata, b_rdata, b_da;
  logic          b_we, b_full, b_pend;
  logic [SA-1:0] s_addr, s_reclen;
  logic [DW-1:0] s_wdata, s_rdata, s_da;
  logic          s_we, s_full, s_pend;

  logic [DW-1:0] b_mem [0:(1<<BA)-1];
  logic [DW-1:0] s_mem [0:(1<<SA)-1];

  int checks = 0;
  int errors = 0;
  int b_we_cnt = 0;
  int s_we_cnt = 0;

  audio_sample_ctrl #(.ADDR_W(BA), .DATA_W(DW), .SKIP(4), .STEP_DIV(STEP)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .State(State), .ClkAD(ClkAD), .ClkDA(ClkDA),
    .AdData(AdData), .MemAddr(b_addr), .MemWData(b_wdata), .MemWe(b_we),
    .MemRData(b_rdata), .DaData(b_da), .RecLen(b_reclen), .Full(b_full),
    .PlayEnd(b_pend)
  );

  audio_sample_ctrl #(.ADDR_W(SA), .DATA_W(DW), .SKIP(4), .STEP_DIV(STEP)) dut_s (
    .Clk(Clk), .Rst_n(Rst_n), .State(State), .ClkAD(ClkAD), .ClkDA(ClkDA),
    .AdData(AdData), .MemAddr(s_addr), .MemWData(s_wdata), .MemWe(s_we),
    .MemRData(s_rdata), .DaData(s_da), .RecLen(s_reclen), .Full(s_full),
    .PlayEnd(s_pend)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous-read memories: data for an address appears one cycle later.
  always @(posedge Clk) begin
    if (b_we) b_mem[b_addr] <= b_wdata;
    b_rdata <= b_mem[b_addr];
    if (s_we) s_mem[s_addr] <= s_wdata;
    s_rdata <= s_mem[s_addr];
  end

  always @(negedge Clk) begin
    if (b_we === 1'b1) b_we_cnt++;
    if (s_we === 1'b1) s_we_cnt++;
  end

  task automatic ad_pulse(input logic [DW-1:0] d);
    @(negedge Clk);
    AdData = d;
    ClkAD  = 1'b1;
    repeat (4) @(negedge Clk);
    ClkAD = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic da_pulse();
    @(negedge Clk);
    ClkDA = 1'b1;
    repeat (4) @(negedge Clk);
    ClkDA = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    State = 3'b000;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (b_addr !== 8'h00)  begin errors++; $display("FAIL reset_addr: got %0h, expected 0", b_addr); end
    checks++; if (b_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %0h, expected 0", b_wdata); end
    checks++; if (b_we !== 1'b0)     begin errors++; $display("FAIL reset_we: got %0b, expected 0", b_we); end
    checks++; if (b_da !== 8'h80)    begin errors++; $display("FAIL reset_da: got %0h, expected 80", b_da); end
    checks++; if (b_reclen !== 8'h00) begin errors++; $display("FAIL reset_reclen: got %0d, expected 0", b_reclen); end
    checks++; if (b_full !== 1'b0 || b_pend !== 1'b0) begin errors++; $display("FAIL reset_flags: got full=%0b end=%0b, expected 0 0", b_full, b_pend); end
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_record();
    logic [DW-1:0] cap_addr, cap_data;
    int pulses, at_edge;
    @(negedge Clk);
    State = 3'b001;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      AdData = 8'(10 + i);
      ClkAD  = 1'b1;
      pulses = 0;
      at_edge = 0;
      cap_addr = '0;
      cap_data = '0;
      for (int k = 1; k <= 6; k++) begin
        @(posedge Clk);
        #1;
        if (b_we === 1'b1) begin
          pulses++;
          at_edge  = k;
          cap_addr = b_addr;
          cap_data = b_wdata;
        end
      end
      ClkAD = 1'b0;
      repeat (3) @(posedge Clk);
      checks++; if (pulses != 1) begin errors++; $display("FAIL rec_pulses[%0d]: got %0d, expected 1", i, pulses); end
      checks++; if (at_edge < 3 || at_edge > 4) begin errors++; $display("FAIL rec_latency[%0d]: got edge %0d, expected 3..4", i, at_edge); end
      checks++; if (cap_addr !== 8'(i)) begin errors++; $display("FAIL rec_addr[%0d]: got %0d, expected %0d", i, cap_addr, i); end
      checks++; if (cap_data !== 8'(10 + i)) begin errors++; $display("FAIL rec_data[%0d]: got %0d, expected %0d", i, cap_data, 10 + i); end
    end
    #1;
    checks++; if (b_reclen !== 8'd5) begin errors++; $display("FAIL rec_len: got %0d, expected 5", b_reclen); end
    checks++; if (b_full !== 1'b0) begin errors++; $display("FAIL rec_full: got %0b, expected 0", b_full); end
  endtask

  task automatic test_playback();
    logic [DW-1:0] d3, d4, d5, d6, prev;
    logic pe3, pe5;
    @(negedge Clk);
    State = 3'b000;
    repeat (2) @(negedge Clk);
    checks++; if (b_da !== 8'h80) begin errors++; $display("FAIL idle_da: got %0h, expected 80", b_da); end
    State = 3'b100;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      ClkDA = 1'b1;
      d3 = '0; d4 = '0; d5 = '0; d6 = '0; pe3 = 1'b0; pe5 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        @(posedge Clk);
        #1;
        if (k == 3) begin d3 = b_da; pe3 = b_pend; end
        if (k == 4) d4 = b_da;
        if (k == 5) begin d5 = b_da; pe5 = b_pend; end
        if (k == 6) d6 = b_da;
      end
      ClkDA = 1'b0;
      repeat (3) @(posedge Clk);
      prev = (i == 0) ? 8'h80 : 8'(9 + i);
      if (i < 5) begin
        checks++; if (d4 !== prev) begin errors++; $display("FAIL play_early[%0d]: got %0d, expected %0d", i, d4, prev); end
        checks++; if (d5 !== 8'(10 + i)) begin errors++; $display("FAIL play_data[%0d]: got %0d, expected %0d", i, d5, 10 + i); end
        checks++; if (pe5 !== 1'b0) begin errors++; $display("FAIL play_end_early[%0d]: got %0b, expected 0", i, pe5); end
      end else begin
        checks++; if (pe3 !== 1'b1) begin errors++; $display("FAIL play_end: got %0b, expected 1", pe3); end
        checks++; if (d3 !== 8'h80 || d6 !== 8'h80) begin errors++; $display("FAIL play_end_da: got %0h/%0h, expected 80/80", d3, d6); end
        checks++; if (b_addr !== 8'd4) begin errors++; $display("FAIL play_end_addr: got %0d, expected 4", b_addr); end
      end
    end
  endtask

  task automatic test_mode_switch();
    int we_snap;
    @(negedge Clk);
    State = 3'b001;
    ad_pulse(8'h21);
    ad_pulse(8'h22);
    checks++; if (b_reclen !== 8'd2) begin errors++; $display("FAIL sw_reclen_pre: got %0d, expected 2", b_reclen); end
    we_snap = b_we_cnt;
    @(negedge Clk);
    AdData = 8'h55;
    ClkAD  = 1'b1;
    ClkDA  = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    State = 3'b100;
    @(posedge Clk);
    #1;
    checks++; if (b_we !== 1'b0) begin errors++; $display("FAIL sw_no_write: got %0b, expected 0", b_we); end
    checks++; if (b_addr !== 8'd0) begin errors++; $display("FAIL sw_read_addr: got %0d, expected 0", b_addr); end
    checks++; if (b_reclen !== 8'd2) begin errors++; $display("FAIL sw_reclen: got %0d, expected 2", b_reclen); end
    @(posedge Clk);
    @(posedge Clk);
    #1;
    checks++; if (b_da !== 8'h21) begin errors++; $display("FAIL sw_read_data: got %0h, expected 21", b_da); end
    ClkAD = 1'b0;
    ClkDA = 1'b0;
    repeat (4) @(negedge Clk);
    checks++; if (b_we_cnt != we_snap) begin errors++; $display("FAIL sw_we_count: got %0d, expected %0d", b_we_cnt, we_snap); end
    checks++; if (b_mem[2] !== 8'd12) begin errors++; $display("FAIL sw_mem2: got %0d, expected 12", b_mem[2]); end
  endtask

  task automatic test_seek();
    int ff_exp [6] = '{7, 11, 15, 19, 20, 20};
    int rw_exp [6] = '{16, 12, 8, 4, 0, 0};
    @(negedge Clk);
    State = 3'b000;
    @(negedge Clk);
    State = 3'b001;
    for (int i = 0; i < 20; i++) ad_pulse(8'(100 + i));
    checks++; if (b_reclen !== 8'd20) begin errors++; $display("FAIL seek_reclen: got %0d, expected 20", b_reclen); end
    @(negedge Clk);
    State = 3'b000;
    @(negedge Clk);
    State = 3'b100;
    for (int i = 0; i < 3; i++) da_pulse();
    checks++; if (dut_b.rd_ptr !== 8'd3) begin errors++; $display("FAIL seek_start_ptr: got %0d, expected 3", dut_b.rd_ptr); end
    checks++; if (b_da !== 8'd102) begin errors++; $display("FAIL seek_start_da: got %0d, expected 102", b_da); end
    State = 3'b110;
    for (int j = 0; j < 6; j++) begin
      repeat (STEP) @(posedge Clk);
      #1;
      checks++; if (dut_b.rd_ptr !== 8'(ff_exp[j])) begin errors++; $display("FAIL ff_step[%0d]: got %0d, expected %0d", j, dut_b.rd_ptr, ff_exp[j]); end
    end
    checks++; if (b_da !== 8'h80) begin errors++; $display("FAIL ff_da: got %0h, expected 80", b_da); end
    State = 3'b111;
    for (int j = 0; j < 6; j++) begin
      repeat (STEP) @(posedge Clk);
      #1;
      checks++; if (dut_b.rd_ptr !== 8'(rw_exp[j])) begin errors++; $display("FAIL rew_step[%0d]: got %0d, expected %0d", j, dut_b.rd_ptr, rw_exp[j]); end
    end
  endtask

  task automatic test_full();
    int sw0;
    @(negedge Clk);
    Rst_n = 1'b0;
    State = 3'b000;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    State = 3'b001;
    sw0 = s_we_cnt;
    for (int i = 1; i <= 16; i++) begin
      ad_pulse(8'(i));
      if (i == 14) begin
        checks++; if (s_full !== 1'b0) begin errors++; $display("FAIL full_early: got %0b, expected 0", s_full); end
      end
      if (i == 15) begin
        checks++; if (s_full !== 1'b1) begin errors++; $display("FAIL full_set: got %0b, expected 1", s_full); end
      end
    end
    checks++; if (s_we_cnt - sw0 != 15) begin errors++; $display("FAIL full_writes: got %0d, expected 15", s_we_cnt - sw0); end
    checks++; if (s_reclen !== 4'd15) begin errors++; $display("FAIL full_reclen: got %0d, expected 15", s_reclen); end
    checks++; if (s_mem[14] !== 8'd15) begin errors++; $display("FAIL full_last_data: got %0d, expected 15", s_mem[14]); end
    checks++; if (b_reclen !== 8'd16 || b_full !== 1'b0) begin errors++; $display("FAIL full_wide: got len=%0d full=%0b, expected 16 0", b_reclen, b_full); end
  endtask

  task automatic test_reset_mid_write();
    int we_snap;
    @(negedge Clk);
    AdData = 8'h77;
    ClkAD  = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b0;
    we_snap = b_we_cnt;
    @(posedge Clk);
    #1;
    checks++; if (b_we !== 1'b0 || s_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b/%0b, expected 0/0", b_we, s_we); end
    checks++; if (b_reclen !== 8'd0 || s_reclen !== 4'd0) begin errors++; $display("FAIL rst_reclen: got %0d/%0d, expected 0/0", b_reclen, s_reclen); end
    checks++; if (b_da !== 8'h80) begin errors++; $display("FAIL rst_da: got %0h, expected 80", b_da); end
    checks++; if (b_addr !== 8'd0 || b_wdata !== 8'd0 || b_full !== 1'b0 || b_pend !== 1'b0 || s_full !== 1'b0)
      begin errors++; $display("FAIL rst_outputs: got addr=%0d wdata=%0d full=%0b end=%0b sfull=%0b, expected all 0", b_addr, b_wdata, b_full, b_pend, s_full); end
    ClkAD = 1'b0;
    State = 3'b000;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (6) @(negedge Clk);
    checks++; if (b_we_cnt != we_snap || b_reclen !== 8'd0) begin errors++; $display("FAIL rst_after: got writes=%0d len=%0d, expected %0d 0", b_we_cnt, b_reclen, we_snap); end
  endtask

  initial begin
    Rst_n  = 1'b0;
    State  = 3'b000;
    ClkAD  = 1'b0;
    ClkDA  = 1'b0;
    AdData = '0;
    test_reset();
    test_record();
    test_playback();
    test_mode_switch();
    test_seek();
    test_full();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
